// File: rtl/rgb_button_if.sv
// Button inputs and LED-facing outputs of the RGB button controller.
// The controller takes the slave side; the button source/LED sink is the master.
interface rgb_button_if;
    logic       btn_sel;
    logic       btn_up;
    logic       btn_down;
    logic       btn_en;
    logic [1:0] sel_ch;
    logic       enabled;
    logic [7:0] r_level;
    logic [7:0] g_level;
    logic [7:0] b_level;
    logic       r_pwm;
    logic       g_pwm;
    logic       b_pwm;

    modport master (
        output btn_sel, btn_up, btn_down, btn_en,
        input  sel_ch, enabled, r_level, g_level, b_level, r_pwm, g_pwm, b_pwm
    );

    modport slave (
        input  btn_sel, btn_up, btn_down, btn_en,
        output sel_ch, enabled, r_level, g_level, b_level, r_pwm, g_pwm, b_pwm
    );
endinterface

// File: rtl/rgb_button_ctrl.sv
// Push-button RGB LED controller: channel select, saturating level adjust with
// hold-to-repeat, output enable, and one 8-bit PWM per channel.
module rgb_button_ctrl #(
    parameter int LEVEL_STEP   = 16,
    parameter int RESET_LEVEL  = 128,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic          clk,
    input  logic          nrst,
    rgb_button_if.slave   bus
);
    typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B, SEL_ALL} sel_e;
    typedef enum logic [1:0] {RP_IDLE, RP_DELAY, RP_REPEAT} rep_e;

    localparam logic [25:0] DLY_LAST  = 26'(REPEAT_DELAY - 1);
    localparam logic [25:0] RATE_LAST = 26'(REPEAT_RATE - 1);
    localparam logic [8:0]  STEP      = 9'(LEVEL_STEP);
    localparam logic [7:0]  RST_LVL   = 8'(RESET_LEVEL);

    sel_e             sel_q, sel_d;
    rep_e             rep_q, rep_d;
    logic             enabled_q, enabled_d;
    logic [2:0][7:0]  level_q, level_d;
    logic [25:0]      hold_cnt_q, hold_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [2:0]       pwm_q, pwm_d;
    logic [3:0]       prev_q, prev_d;

    logic [3:0]       btn, press;
    logic             hold, rep_tick, up_ev, dn_ev;
    logic [8:0]       sum, diff;

    // Button vector order: {en, down, up, sel}
    assign btn    = {bus.btn_en, bus.btn_down, bus.btn_up, bus.btn_sel};
    assign press  = btn & ~prev_q;
    assign prev_d = btn;
    assign hold   = enabled_q & (bus.btn_up ^ bus.btn_down);

    // Auto-repeat: a fresh press restarts the delay; losing the hold aborts silently.
    always_comb begin
        rep_d      = rep_q;
        hold_cnt_d = hold_cnt_q;
        rep_tick   = 1'b0;
        if (!hold) begin
            rep_d      = RP_IDLE;
            hold_cnt_d = '0;
        end else if (press[1] | press[2]) begin
            rep_d      = RP_DELAY;
            hold_cnt_d = '0;
        end else begin
            case (rep_q)
                RP_DELAY: begin
                    if (hold_cnt_q == DLY_LAST) begin
                        rep_tick   = 1'b1;
                        hold_cnt_d = '0;
                        rep_d      = RP_REPEAT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 26'd1;
                    end
                end
                RP_REPEAT: begin
                    if (hold_cnt_q == RATE_LAST) begin
                        rep_tick   = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 26'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign up_ev = enabled_q & (press[1] | (rep_tick & bus.btn_up));
    assign dn_ev = enabled_q & (press[2] | (rep_tick & bus.btn_down));

    // Steps target the pre-advance selection; each channel clamps on its own.
    always_comb begin
        sel_d     = sel_q;
        enabled_d = enabled_q ^ press[3];
        level_d   = level_q;
        sum       = '0;
        diff      = '0;
        if (enabled_q & press[0])
            sel_d = sel_e'(sel_q + 2'd1);
        for (int c = 0; c < 3; c++) begin
            sum  = {1'b0, level_q[c]} + STEP;
            diff = {1'b0, level_q[c]} - STEP;
            if ((sel_q == SEL_ALL || sel_q == sel_e'(c)) && (up_ev ^ dn_ev))
                level_d[c] = up_ev ? (sum[8]  ? 8'hFF : sum[7:0])
                                   : (diff[8] ? 8'h00 : diff[7:0]);
        end
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_d     = '0;
        for (int c = 0; c < 3; c++)
            pwm_d[c] = enabled_q & (pwm_cnt_q < level_q[c]);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sel_q      <= SEL_R;
            rep_q      <= RP_IDLE;
            enabled_q  <= 1'b1;
            level_q    <= {3{RST_LVL}};
            hold_cnt_q <= '0;
            pwm_cnt_q  <= '0;
            pwm_q      <= '0;
            prev_q     <= '0;
        end else begin
            sel_q      <= sel_d;
            rep_q      <= rep_d;
            enabled_q  <= enabled_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_q      <= pwm_d;
            prev_q     <= prev_d;
        end
    end

    assign bus.sel_ch  = sel_q;
    assign bus.enabled = enabled_q;
    assign bus.r_level = level_q[0];
    assign bus.g_level = level_q[1];
    assign bus.b_level = level_q[2];
    assign bus.r_pwm   = pwm_q[0];
    assign bus.g_pwm   = pwm_q[1];
    assign bus.b_pwm   = pwm_q[2];
endmodule

// File: tb/tb_rgb_button_ctrl.sv
// Bench for rgb_button_ctrl: table of single-press vectors plus hand-written
// hold, PWM, disable and reset sequences, all checked through a scoreboard queue.
module tb_rgb_button_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    rgb_button_if bus();

    rgb_button_ctrl #(
        .LEVEL_STEP(16), .RESET_LEVEL(128), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) dut (
        .clk(clk), .nrst(nrst), .bus(bus)
    );

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic [7:0] r, g, b;
    } exp_t;

    typedef struct {
        logic s, u, d, e;
        exp_t x;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[31];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mke(input int sel, input int en, input int r, input int g, input int b);
        exp_t x;
        x.sel = 2'(sel); x.en = 1'(en); x.r = 8'(r); x.g = 8'(g); x.b = 8'(b);
        return x;
    endfunction

    function automatic vec_t mkv(input logic s, input logic u, input logic d, input logic e, input exp_t x);
        vec_t v;
        v.s = s; v.u = u; v.d = d; v.e = e; v.x = x;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_state(input string nm);
        exp_t x;
        if (sb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        chk({nm, " sel"}, 32'(bus.sel_ch),  32'(x.sel));
        chk({nm, " en"},  32'(bus.enabled), 32'(x.en));
        chk({nm, " r"},   32'(bus.r_level), 32'(x.r));
        chk({nm, " g"},   32'(bus.g_level), 32'(x.g));
        chk({nm, " b"},   32'(bus.b_level), 32'(x.b));
    endtask

    task automatic set_btn(input logic s, input logic u, input logic d, input logic e);
        bus.btn_sel = s; bus.btn_up = u; bus.btn_down = d; bus.btn_en = e;
    endtask

    // One-cycle press; result is checked one edge later, then a release cycle.
    task automatic press(input logic s, input logic u, input logic d, input logic e,
                         input exp_t x, input string nm);
        set_btn(s, u, d, e);
        sb.push_back(x);
        @(negedge clk);
        cmp_state(nm);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic count_pwm(output int rc, output int gc, output int bc);
        rc = 0; gc = 0; bc = 0;
        repeat (256) begin
            @(negedge clk);
            rc += int'(bus.r_pwm);
            gc += int'(bus.g_pwm);
            bc += int'(bus.b_pwm);
        end
    endtask

    initial begin
        int rc, gc, bc;
        int er, eg, eb, ge;

        for (int i = 0; i < 7; i++)
            tbl[i] = mkv(1'b0, 1'b1, 1'b0, 1'b0, mke(0, 1, 144 + 16 * i, 128, 128));
        tbl[7] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mke(1, 1, 240, 128, 128));
        for (int i = 8; i < 15; i++)
            tbl[i] = mkv(1'b0, 1'b0, 1'b1, 1'b0, mke(1, 1, 240, 112 - 16 * (i - 8), 128));
        tbl[15] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mke(2, 1, 240, 16, 128));
        tbl[16] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mke(3, 1, 240, 16, 128));
        tbl[17] = mkv(1'b0, 1'b1, 1'b0, 1'b0, mke(3, 1, 255, 32, 144));
        tbl[18] = mkv(1'b0, 1'b0, 1'b1, 1'b0, mke(3, 1, 239, 16, 128));
        tbl[19] = mkv(1'b0, 1'b0, 1'b1, 1'b0, mke(3, 1, 223, 0, 112));
        tbl[20] = mkv(1'b0, 1'b0, 1'b1, 1'b0, mke(3, 1, 207, 0, 96));
        tbl[21] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mke(0, 1, 207, 0, 96));
        tbl[22] = mkv(1'b0, 1'b1, 1'b1, 1'b0, mke(0, 1, 207, 0, 96));
        tbl[23] = mkv(1'b1, 1'b1, 1'b0, 1'b0, mke(1, 1, 223, 0, 96));
        tbl[24] = mkv(1'b0, 1'b0, 1'b0, 1'b1, mke(1, 0, 223, 0, 96));
        tbl[25] = mkv(1'b0, 1'b1, 1'b0, 1'b0, mke(1, 0, 223, 0, 96));
        tbl[26] = mkv(1'b1, 1'b0, 1'b0, 1'b0, mke(1, 0, 223, 0, 96));
        tbl[27] = mkv(1'b0, 1'b0, 1'b0, 1'b1, mke(1, 1, 223, 0, 96));
        tbl[28] = mkv(1'b0, 1'b1, 1'b0, 1'b1, mke(1, 0, 223, 16, 96));
        tbl[29] = mkv(1'b0, 1'b0, 1'b0, 1'b1, mke(1, 1, 223, 16, 96));
        tbl[30] = mkv(1'b1, 1'b0, 1'b1, 1'b0, mke(2, 1, 223, 0, 96));

        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        sb.push_back(mke(0, 1, 128, 128, 128));
        cmp_state("reset");
        chk("reset pwm", 32'({bus.r_pwm, bus.g_pwm, bus.b_pwm}), 32'd0);
        nrst = 1'b1;

        count_pwm(rc, gc, bc);
        chk("pwm r duty 128", 32'(rc), 32'd128);

        for (int i = 0; i < 31; i++)
            press(tbl[i].s, tbl[i].u, tbl[i].d, tbl[i].e, tbl[i].x, $sformatf("vec%0d", i));

        count_pwm(rc, gc, bc);
        chk("pwm r duty 223", 32'(rc), 32'd223);
        chk("pwm g duty 0",   32'(gc), 32'd0);
        chk("pwm b duty 96",  32'(bc), 32'd96);

        press(1'b0, 1'b0, 1'b0, 1'b1, mke(2, 0, 223, 0, 96), "disable");
        count_pwm(rc, gc, bc);
        chk("pwm off while disabled", 32'(rc + gc + bc), 32'd0);
        press(1'b0, 1'b0, 1'b0, 1'b1, mke(2, 1, 223, 0, 96), "reenable");
        count_pwm(rc, gc, bc);
        chk("pwm b resumes", 32'(bc), 32'd96);

        press(1'b1, 1'b0, 1'b0, 1'b0, mke(3, 1, 223, 0, 96), "sel all");
        er = 223; eg = 0; eb = 96;
        for (int i = 0; i < 20; i++) begin
            er = (er > 16) ? er - 16 : 0;
            eg = (eg > 16) ? eg - 16 : 0;
            eb = (eb > 16) ? eb - 16 : 0;
            press(1'b0, 1'b0, 1'b1, 1'b0, mke(3, 1, er, eg, eb), $sformatf("all down%0d", i));
        end
        chk("all floor sum", 32'(bus.r_level) + 32'(bus.g_level) + 32'(bus.b_level), 32'd0);
        press(1'b1, 1'b0, 1'b0, 1'b0, mke(0, 1, 0, 0, 0), "sel r");
        press(1'b1, 1'b0, 1'b0, 1'b0, mke(1, 1, 0, 0, 0), "sel g");

        // Hold up for 40 edges: steps at edges 1, 21, 26, 31, 36.
        bus.btn_up = 1'b1;
        ge = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1 || c == 21 || c == 26 || c == 31 || c == 36) ge += 16;
            sb.push_back(mke(1, 1, 0, ge, 0));
            @(negedge clk);
            cmp_state($sformatf("hold c%0d", c));
        end
        bus.btn_up = 1'b0;
        repeat (10) @(negedge clk);
        chk("no step after release", 32'(bus.g_level), 32'd80);

        set_btn(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        chk("both held no change", 32'(bus.g_level), 32'd80);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset asserted mid-repeat, between clock edges.
        bus.btn_up = 1'b1;
        repeat (25) @(negedge clk);
        chk("pre-reset g", 32'(bus.g_level), 32'd112);
        #2 nrst = 1'b0;
        #1;
        sb.push_back(mke(0, 1, 128, 128, 128));
        cmp_state("async reset");
        chk("async reset pwm", 32'({bus.r_pwm, bus.g_pwm, bus.b_pwm}), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        sb.push_back(mke(0, 1, 144, 128, 128));
        @(negedge clk);
        cmp_state("held through reset");
        bus.btn_up = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
